// File: rtl/multiport_regfile_pkg.sv
// Shared types and default sizes for the multiport register file and its clear controller.
package multiport_regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Bulk-clear sequencer: walks an index from 0 to DEPTH-1, one entry per cycle,
// and returns to IDLE on the edge that zeroes the last entry.
module regfile_clear_ctrl
  import multiport_regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_we,
  output clr_state_e        clr_state
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // clr_req is only looked at in IDLE, so a request during a clear neither restarts nor extends it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          idx_d   = '0;
        end
      end
      CLR_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == '1) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign clr_busy  = (state_q == CLR_CLEAR);
  assign clr_we    = clr_busy;
  assign clr_idx   = idx_q;
  assign clr_state = state_q;

endmodule

// File: rtl/multiport_regfile.sv
// Register file with one write port, two registered read ports, optional
// write-to-read bypass, optional hardwired-zero entry 0, and a bulk clear.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_err,
  output clr_state_e        clr_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] ra_data_q, ra_data_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              wr_err_q, wr_err_d;
  logic              busy;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_we;
  logic              zero_hit;
  logic              wr_ok;

  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .clr_busy  (busy),
    .clr_idx   (clr_idx),
    .clr_we    (clr_we),
    .clr_state (clr_state)
  );

  // Writes to a hardwired-zero entry vanish silently; any other write during a clear is dropped and flagged.
  always_comb begin
    zero_hit = ZERO_REG && (waddr == '0);
    wr_ok    = we && !busy && !zero_hit;
    wr_err_d = we && busy && !zero_hit;

    mem_d = mem_q;
    if (clr_we)     mem_d[clr_idx] = '0;
    else if (wr_ok) mem_d[waddr]   = wdata;

    ra_data_d = (BYPASS && wr_ok && (waddr == ra_addr)) ? wdata : mem_q[ra_addr];
    if (ZERO_REG && (ra_addr == '0)) ra_data_d = '0;
    rb_data_d = (BYPASS && wr_ok && (waddr == rb_addr)) ? wdata : mem_q[rb_addr];
    if (ZERO_REG && (rb_addr == '0)) rb_data_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ra_data_q <= '0;
      rb_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign ra_data  = ra_data_q;
  assign rb_data  = rb_data_q;
  assign wr_err   = wr_err_q;
  assign clr_busy = busy;

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: default, no-bypass and zero-register instances share one stimulus stream.
module tb_multiport_regfile;
  import multiport_regfile_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, we, clr_req;
  logic [AW-1:0] waddr, ra_addr, rb_addr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] ra_data, rb_data, nb_ra_data, nb_rb_data, z_ra_data, z_rb_data;
  logic          clr_busy, wr_err, nb_clr_busy, nb_wr_err, z_clr_busy, z_wr_err;
  clr_state_e    clr_state, nb_clr_state, z_clr_state;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] model [DEPTH];

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_err(wr_err), .clr_state(clr_state)
  );

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(nb_ra_data), .rb_data(nb_rb_data),
    .clr_req(clr_req), .clr_busy(nb_clr_busy), .wr_err(nb_wr_err), .clr_state(nb_clr_state)
  );

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(z_ra_data), .rb_data(z_rb_data),
    .clr_req(clr_req), .clr_busy(z_clr_busy), .wr_err(z_wr_err), .clr_state(z_clr_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    we      = 1'b0;
    clr_req = 1'b0;
    waddr   = '0;
    wdata   = '0;
    ra_addr = '0;
    rb_addr = '0;
    #12;
    n_checks++;
    if ({ra_data, rb_data} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h exp 0000/0000", ra_data, rb_data);
    end
    n_checks++;
    if ({clr_busy, wr_err, clr_state} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/err/state got %b%b%b exp 000", clr_busy, wr_err, clr_state);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    ra_addr = 3'd5;
    rb_addr = 3'd7;
    exp_q.push_back(16'h0000);
    step();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v) begin
      n_fail++;
      $display("FAIL reset_entry: got %h exp %h", ra_data, exp_v);
    end
  endtask

  task automatic test_bypass();
    we      = 1'b1;
    waddr   = 3'd2;
    wdata   = 16'h1234;
    ra_addr = 3'd2;
    rb_addr = 3'd6;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0000);
    step();
    we = 1'b0;
    model[2] = 16'h1234;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_on: got %h exp %h", ra_data, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (nb_ra_data !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_off_old: got %h exp %h", nb_ra_data, exp_v);
    end
    exp_q.push_back(16'h1234);
    step();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (nb_ra_data !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_off_next: got %h exp %h", nb_ra_data, exp_v);
    end
  endtask

  task automatic test_write_read();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    write(3'd5, 16'hBEEF);
    model[5] = 16'hBEEF;
    ra_addr = 3'd5;
    rb_addr = 3'd5;
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'hBEEF);
    step();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v) begin
      n_fail++;
      $display("FAIL wr_rd_a: got %h exp %h", ra_data, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rb_data !== exp_v) begin
      n_fail++;
      $display("FAIL wr_rd_b: got %h exp %h", rb_data, exp_v);
    end
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(1, DEPTH - 1));
      d = DW'($urandom_range(0, 16'hFFFF));
      write(a, d);
      model[a] = d;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra_addr = AW'(i);
      rb_addr = AW'(DEPTH - 1 - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[DEPTH - 1 - i]);
      step();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (ra_data !== exp_v) begin
        n_fail++;
        $display("FAIL sweep_a[%0d]: got %h exp %h", i, ra_data, exp_v);
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rb_data !== exp_v) begin
        n_fail++;
        $display("FAIL sweep_b[%0d]: got %h exp %h", DEPTH - 1 - i, rb_data, exp_v);
      end
    end
  endtask

  task automatic test_zero_reg();
    we      = 1'b1;
    waddr   = 3'd0;
    wdata   = 16'h5555;
    ra_addr = 3'd0;
    rb_addr = 3'd0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h5555);
    step();
    we = 1'b0;
    model[0] = 16'h5555;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (z_ra_data !== exp_v || z_wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg_wr: data %h err %b exp %h err 0", z_ra_data, z_wr_err, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v) begin
      n_fail++;
      $display("FAIL zero_reg_off: got %h exp %h", ra_data, exp_v);
    end
    exp_q.push_back(16'h0000);
    step();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (z_rb_data !== exp_v || z_wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg_rd: data %h err %b exp %h err 0", z_rb_data, z_wr_err, exp_v);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      write(AW'(i), 16'hFFFF);
      model[i] = 16'hFFFF;
    end
    clr_req = 1'b1;
    step();
    clr_req  = 1'b0;
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 20) begin
      busy_cnt++;
      clr_req = (busy_cnt == 2);
      if (busy_cnt == 3) begin
        ra_addr = 3'd7;
        exp_q.push_back(16'hFFFF);
      end
      if (busy_cnt == 4) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (ra_data !== exp_v) begin
          n_fail++;
          $display("FAIL clear_mid_read: got %h exp %h", ra_data, exp_v);
        end
      end
      step();
    end
    clr_req = 1'b0;
    n_checks++;
    if (busy_cnt != DEPTH || clr_state !== CLR_IDLE) begin
      n_fail++;
      $display("FAIL clear_len: busy cycles %0d state %0d exp %0d state 0", busy_cnt, clr_state, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ra_addr = AW'(i);
      rb_addr = AW'(DEPTH - 1 - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[DEPTH - 1 - i]);
      step();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (ra_data !== exp_v) begin
        n_fail++;
        $display("FAIL clear_sweep_a[%0d]: got %h exp %h", i, ra_data, exp_v);
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rb_data !== exp_v) begin
        n_fail++;
        $display("FAIL clear_sweep_b[%0d]: got %h exp %h", DEPTH - 1 - i, rb_data, exp_v);
      end
    end
  endtask

  task automatic test_dropped_write();
    int wait_cnt;
    // Write and clear request together: the write lands, then gets cleared in turn.
    we      = 1'b1;
    waddr   = 3'd1;
    wdata   = 16'h1111;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n_checks++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_and_clr_busy: got %b exp 1", clr_busy);
    end
    waddr   = 3'd1;
    wdata   = 16'hAAAA;
    ra_addr = 3'd1;
    exp_q.push_back(16'h1111);
    step();
    we = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v || wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_pulse: data %h err %b exp %h err 1", ra_data, wr_err, exp_v);
    end
    step();
    n_checks++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse_width: got %b exp 0", wr_err);
    end
    wait_cnt = 0;
    while (clr_busy === 1'b1 && wait_cnt < 20) begin
      wait_cnt++;
      step();
    end
    ra_addr = 3'd1;
    exp_q.push_back(16'h0000);
    step();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_after: data %h busy %b exp %h busy 0", ra_data, clr_busy, exp_v);
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    write(3'd7, 16'h7777);
    ra_addr = 3'd7;
    rb_addr = 3'd7;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (3) step();
    n_checks++;
    if (ra_data !== 16'h7777 || clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: data %h busy %b exp 7777 busy 1", ra_data, clr_busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ra_data, rb_data} !== 32'h0 || {clr_busy, wr_err, clr_state} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_clear_reset: data %h/%h busy/err/state %b%b%b exp 0", ra_data, rb_data, clr_busy, wr_err, clr_state);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_q.push_back(model[7]);
    step();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (ra_data !== exp_v || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: data %h busy %b exp %h busy 0", ra_data, clr_busy, exp_v);
    end
    clr_req = 1'b1;
    step();
    clr_req  = 1'b0;
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 20) begin
      busy_cnt++;
      step();
    end
    n_checks++;
    if (busy_cnt != DEPTH) begin
      n_fail++;
      $display("FAIL post_reset_clear_len: got %0d exp %0d", busy_cnt, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_write_read();
    test_zero_reg();
    test_clear();
    test_dropped_write();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write forwarded to read ports.
REQ-004 SHALL have parameter ZERO_REG, default 0, 1 = entry 0 hardwired to zero.
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  ADDR_W  write address.
REQ-009 SHALL have port wdata  input  DATA_W  write data.
REQ-010 SHALL have port ra_addr  input  ADDR_W  read port A address.
REQ-011 SHALL have port rb_addr  input  ADDR_W  read port B address.
REQ-012 SHALL have port ra_data  output  DATA_W  read port A data, registered.
REQ-013 SHALL have port rb_data  output  DATA_W  read port B data, registered.
REQ-014 SHALL have port clr_req  input  1  single-cycle request to start a bulk clear.
REQ-015 SHALL have port clr_busy  output  1  high while a bulk clear is in progress.
REQ-016 SHALL have port wr_err  output  1  one-cycle pulse: a write was dropped.

Function
REQ-017 SHALL give each read port 1-cycle latency: data for the address sampled at edge N appears after edge N and holds until the next edge.
REQ-018 SHALL make port A and port B fully independent; both may read the same address in the same cycle.
REQ-019 SHALL, when BYPASS=1, we=1 and waddr equals a read address in the same cycle, return wdata on that port; when BYPASS=0, that port returns the old contents.
REQ-020 SHALL, when ZERO_REG=1, always read 0 at address 0, silently ignore writes to address 0, and never assert wr_err for them.
REQ-021 SHALL implement a clear FSM with states IDLE and CLEAR.
- IDLE -> CLEAR on clr_req=1.
- CLEAR -> IDLE after the edge that zeroes index DEPTH-1.
REQ-022 SHALL, in CLEAR, zero one entry per cycle, with index counting 0 to DEPTH-1, so a clear takes exactly DEPTH cycles.
REQ-023 SHALL drive clr_busy = (state == CLEAR), registered: high from the edge after clr_req until the edge after the last entry is zeroed.
REQ-024 SHALL ignore clr_req while in CLEAR; no restart and no extension.
REQ-025 SHALL, when we=1 in CLEAR, drop the write and pulse wr_err for one cycle after that edge; no bypass applies to a dropped write.
REQ-026 SHALL, for reads during CLEAR, return the current array contents: entries already zeroed read 0, entries not yet reached read their old value.
REQ-027 SHALL, when clr_req=1 and we=1 arrive together in IDLE, perform the write and enter CLEAR; the written entry is then zeroed in its turn.
REQ-028 SHALL wrap-free address all entries; every ADDR_W value is valid.

Reset
REQ-029 SHALL, while reset is high, asynchronously set all entries to 0, ra_data/rb_data to 0, clr_busy to 0, wr_err to 0, the FSM to IDLE and the clear index to 0.
REQ-030 SHALL, on reset during CLEAR, abort the clear immediately; after reset deasserts, the block is in IDLE with all entries 0.

Structure
REQ-031 SHALL place the FSM state enum and the default DATA_W/ADDR_W constants in a shared package, multiport_regfile_pkg.
REQ-032 SHALL implement the clear FSM and index counter as one sub-module, regfile_clear_ctrl, with outputs clr_busy, clr_idx and clr_we.

Verification (DATA_W=16, ADDR_W=3 unless stated)
REQ-033 SHALL cover write then read: write 0xBEEF to addr 5, read A=5 and B=5 in the next cycle -> both ports return 0xBEEF one cycle later.
REQ-034 SHALL cover bypass: BYPASS=1, write 0x1234 to addr 2 while ra_addr=2 -> ra_data=0x1234 after that edge. With BYPASS=0 the same stimulus -> ra_data shows the old value 0x0000.
REQ-035 SHALL cover bulk clear: fill all 8 entries with 0xFFFF, pulse clr_req -> clr_busy is high for exactly 8 cycles and all entries read 0 afterwards. A mid-clear read of addr 7 at cycle 3 -> returns 0xFFFF.
REQ-036 SHALL cover a dropped write: we=1, addr 1, 0xAAAA during CLEAR -> wr_err pulses for 1 cycle and addr 1 reads 0 after the clear.
REQ-037 SHALL cover the zero register: ZERO_REG=1, write 0x5555 to addr 0 -> reads of addr 0 return 0 and wr_err stays 0.
REQ-038 SHALL cover reset mid-clear: assert reset at clear cycle 4 -> all outputs are 0 immediately, state is IDLE, and a later clr_req starts a full 8-cycle clear.
